// File: rtl/dna_loader.sv
// Packs a serial 2-bit nucleotide stream eight-per-word into sequence memory,
// then hands the base address and length to the search engine.
module dna_loader #(
    parameter logic [15:0] MAX_NUC = 16'd4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic        nuc_valid,
    input  logic [1:0]  nuc,
    input  logic        nuc_last,
    output logic        nuc_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] dna_start,
    output logic [15:0] dna_length,
    output logic        search_ready,
    input  logic        search_done,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_HANDOFF,
        S_WAIT
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] count_reg;
    logic [15:0] pack_reg;
    logic [15:0] base_reg;
    logic        mem_we_reg;
    logic [15:0] mem_addr_reg;
    logic [15:0] mem_wdata_reg;
    logic [15:0] dna_start_reg;
    logic [15:0] dna_length_reg;
    logic        error_reg;

    logic        accept;
    logic        full;
    logic [2:0]  slot;
    logic [15:0] pack_merged;
    logic [15:0] word_addr;

    assign accept    = (state_reg == S_LOAD) && nuc_valid;
    assign full      = (count_reg == MAX_NUC);
    assign slot      = count_reg[2:0];
    assign word_addr = base_reg + {3'b000, count_reg[15:3]};

    // Pack register with the incoming nucleotide dropped into the current slot.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slot
            assign pack_merged[2*gi +: 2] = (slot == 3'(gi)) ? nuc : pack_reg[2*gi +: 2];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start) state_next = S_LOAD;
            S_LOAD:    if (accept && nuc_last) state_next = S_FLUSH;
            S_FLUSH:   state_next = S_HANDOFF;
            S_HANDOFF: state_next = S_WAIT;
            S_WAIT:    if (search_done) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            count_reg      <= '0;
            pack_reg       <= '0;
            base_reg       <= '0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            dna_start_reg  <= '0;
            dna_length_reg <= '0;
            error_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        base_reg  <= base_addr;
                        count_reg <= '0;
                        pack_reg  <= '0;
                        error_reg <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (full) begin
                            error_reg <= 1'b1;
                            // Partial word left over when the cap is not word aligned.
                            if (nuc_last && (slot != 3'd0)) begin
                                mem_we_reg    <= 1'b1;
                                mem_addr_reg  <= word_addr;
                                mem_wdata_reg <= pack_reg;
                            end
                        end else begin
                            count_reg <= count_reg + 16'd1;
                            if ((slot == 3'd7) || nuc_last) begin
                                mem_we_reg    <= 1'b1;
                                mem_addr_reg  <= word_addr;
                                mem_wdata_reg <= pack_merged;
                                pack_reg      <= '0;
                            end else begin
                                pack_reg <= pack_merged;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    dna_start_reg  <= base_reg;
                    dna_length_reg <= count_reg;
                end
                default: ;
            endcase
        end
    end

    assign nuc_ready    = (state_reg == S_LOAD);
    assign busy         = (state_reg != S_IDLE);
    assign search_ready = (state_reg == S_HANDOFF);
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign dna_start    = dna_start_reg;
    assign dna_length   = dna_length_reg;
    assign error        = error_reg;

endmodule
